// File: rtl/node_inject_arbiter.sv
// Round-robin arbiter sharing one router injection port among NREQ local sources.
// Define ARB_TIMESTAMP_EN to stamp packets with the grant-cycle counter instead of the source stamp.
module node_inject_arbiter #(
    parameter int NREQ  = 4,
    parameter int PKT_W = 40,
    parameter int GID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            node_addr,
    input  logic [31:0]           ctr,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*PKT_W-1:0] req_pkt,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [PKT_W-1:0]      out_pkt,
    input  logic                  out_ready,
    output logic [GID_W-1:0]      grant_id,
    output logic [15:0]           drop_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [GID_W-1:0] rr_ptr;
    logic [GID_W-1:0] win_idx;
    logic             win_found;
    logic             slot_free;
    logic             accept;
    logic             self_addr;
    logic             load;
    logic [PKT_W-1:0] pkt_sel;
    logic [31:0]      stamp;
    logic             unused_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Scan starts just past the last winner so every valid source is reached within NREQ grants.
    always_comb begin
        int unsigned idx;
        logic [GID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(rr_ptr) + k) % NREQ;
            cand = GID_W'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign slot_free = (state == EMPTY) || ((state == FULL) && out_ready);
    assign accept    = slot_free && win_found;
    assign pkt_sel   = req_pkt[win_idx*PKT_W +: PKT_W];
    assign self_addr = (pkt_sel[3:0] == node_addr);
    assign load      = accept && !self_addr;

`ifdef ARB_TIMESTAMP_EN
    assign stamp       = ctr;
    assign unused_bits = ^pkt_sel[PKT_W-1:4];
`else
    assign stamp       = pkt_sel[PKT_W-1:8];
    assign unused_bits = ^{ctr, pkt_sel[7:4]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (out_ready) state_nxt = load ? FULL : EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        req_ready = accept ? (NREQ'(1) << win_idx) : '0;
    end

    // Self-addressed packets advance the pointer but never occupy the output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pkt  <= '0;
            grant_id <= '0;
            drop_cnt <= '0;
            rr_ptr   <= GID_W'(NREQ - 1);
        end else if (accept) begin
            rr_ptr <= win_idx;
            if (self_addr) begin
                drop_cnt <= sat_inc(drop_cnt);
            end else begin
                out_pkt  <= {stamp, node_addr, pkt_sel[3:0]};
                grant_id <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_node_inject_arbiter.sv
// Self-checking bench for node_inject_arbiter: directed scenarios plus a randomized phase
// checked against a cycle-level packet model.
module tb_node_inject_arbiter;

    localparam int NREQ  = 4;
    localparam int PKT_W = 40;
    localparam int GID_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [3:0]            node_addr = '0;
    logic [31:0]           ctr = '0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*PKT_W-1:0] req_pkt = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [PKT_W-1:0]      out_pkt;
    logic                  out_ready = 1'b0;
    logic [GID_W-1:0]      grant_id;
    logic [15:0]           drop_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // reference model state
    bit               m_held;
    logic [PKT_W-1:0] m_pkt;
    int               m_gid;
    int               m_last;
    int               m_drops;
    int               last_win;

    node_inject_arbiter #(.NREQ(NREQ), .PKT_W(PKT_W), .GID_W(GID_W)) dut (
        .clk(clk), .rst_n(rst_n), .node_addr(node_addr), .ctr(ctr),
        .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(req_ready),
        .out_valid(out_valid), .out_pkt(out_pkt), .out_ready(out_ready),
        .grant_id(grant_id), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] dest, input logic [3:0] src,
                           input logic [31:0] st);
        req_pkt[i*PKT_W +: PKT_W] = {st, src, dest};
    endtask

    task automatic model_reset();
        m_held  = 0;
        m_pkt   = '0;
        m_gid   = 0;
        m_last  = NREQ - 1;
        m_drops = 0;
    endtask

    // Asserts reset from any point in time; ends at a falling edge with reset released.
    task automatic do_reset(input logic [3:0] na);
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pkt", out_pkt, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        model_reset();
        node_addr = na;
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic cycle();
        int win;
        bit free;
        logic [NREQ-1:0] exp_ready;
        logic [PKT_W-1:0] p;
        logic [31:0] st;
        free = !m_held || out_ready;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (win < 0 && req_valid[i]) win = i;
        end
        exp_ready = '0;
        if (free && win >= 0) exp_ready[win] = 1'b1;
        #1;
        check("req_ready", req_ready, exp_ready);
        @(posedge clk);
        if (m_held && out_ready) m_held = 0;
        last_win = -1;
        if (exp_ready != '0) begin
            last_win = win;
            m_last = win;
            p = req_pkt[win*PKT_W +: PKT_W];
            if (p[3:0] == node_addr) begin
                if (m_drops < 65535) m_drops++;
            end else begin
`ifdef ARB_TIMESTAMP_EN
                st = ctr;
`else
                st = p[39:8];
`endif
                m_pkt  = {st, node_addr, p[3:0]};
                m_gid  = win;
                m_held = 1;
            end
        end
        #1;
        check("out_valid", out_valid, m_held);
        check("out_pkt", out_pkt, m_pkt);
        check("grant_id", grant_id, m_gid);
        check("drop_cnt", drop_cnt, m_drops);
        @(negedge clk);
        ctr = ctr + 1;
    endtask

    initial begin
        int order [6];
        logic [PKT_W-1:0] held;
        logic [PKT_W-1:0] exp_pkt;
        bit pend [NREQ];
        order = '{0, 1, 2, 3, 0, 1};
        model_reset();
        @(negedge clk);
        do_reset(4'd5);

        // single request from source 1
        set_req(1, 4'd9, 4'd0, 32'd7);
        req_valid = 4'b0010;
        ctr = 32'd100;
        out_ready = 1'b1;
        cycle();
`ifdef ARB_TIMESTAMP_EN
        exp_pkt = {32'd100, 4'd5, 4'd9};
`else
        exp_pkt = {32'd7, 4'd5, 4'd9};
`endif
        check("t2_pkt", out_pkt, exp_pkt);
        check("t2_gid", grant_id, 1);
        check("t2_valid", out_valid, 1);
        req_valid = '0;
        cycle();
        check("t2_drain", out_valid, 0);

        // round-robin with all sources valid
        do_reset(4'd5);
        for (int i = 0; i < NREQ; i++) set_req(i, 4'(8 + i), 4'd0, 32'(1000 + i));
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t3_grant", grant_id, order[k]);
            check("t3_valid", out_valid, 1);
        end

        // backpressure then same-cycle drain and refill
        held = out_pkt;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t4_stable", out_pkt, held);
            check("t4_ready0", req_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("t4_refill_gid", grant_id, 2);
        check("t4_refill_valid", out_valid, 1);

        // reset in the middle of a held packet
        out_ready = 1'b0;
        #3;
        do_reset(4'd3);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        cycle();
        check("t1_first_gid", grant_id, 0);

        // self-addressed drops
        do_reset(4'd3);
        set_req(0, 4'd3, 4'd1, 32'd55);
        set_req(1, 4'd4, 4'd1, 32'd66);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        cycle();
        check("t5_drop1", drop_cnt, 1);
        check("t5_no_out", out_valid, 0);
        req_valid = 4'b0011;
        cycle();
        check("t5_emit_gid", grant_id, 1);
        check("t5_emit_dest", out_pkt[3:0], 4'd4);
        req_valid = 4'b0001;
        cycle();
        check("t5_drop2", drop_cnt, 2);
        req_valid = '0;
        cycle();
        check("t5_empty", out_valid, 0);

        // randomized traffic with pending-until-accepted sources
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    set_req(i, ($urandom_range(0, 3) == 0) ? node_addr : 4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 15)), $urandom());
                end
                req_valid[i] = pend[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_win >= 0) pend[last_win] = 0;
        end

        // drop counter saturation
        do_reset(4'd6);
        set_req(0, 4'd6, 4'd0, 32'd1);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("t6_pre_sat", drop_cnt, 65534);
        m_drops = 65534;
        m_last = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) cycle();
        check("t6_saturated", drop_cnt, 16'hFFFF);
        check("t6_no_out", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
